// File: rtl/durum_zamanlayici.sv
// durum_zamanlayici: shares one external serial detector FSM between two requesters.
// A granted word is fed into the FSM LSB first. The FSM's Moore output is sampled after
// every bit, and the collected bits are published as one result word.
//
// Ports:
//   saat            clock, rising edge
//   reset           asynchronous, active-low
//   istek0/1        job request, held until the matching kabul pulse
//   veri0/1         input word of each requester, sampled at grant
//   kabul0/1        one-cycle grant pulse (the TEMIZLE cycle of the job)
//   fsm_reset       synchronous reset to the external FSM
//   fsm_giris       serial bit into the external FSM
//   fsm_cikis       registered Moore output of the external FSM
//   sonuc           collected FSM outputs of the last completed job
//   sonuc_gecerli   one-cycle pulse when sonuc is updated
//   sonuc_kimlik    requester index that owns sonuc
//   mesgul          controller is not idle
module durum_zamanlayici #(
    parameter int unsigned UZUNLUK = 8
) (
    input  logic               saat,
    input  logic               reset,
    input  logic               istek0,
    input  logic               istek1,
    input  logic [UZUNLUK-1:0] veri0,
    input  logic [UZUNLUK-1:0] veri1,
    output logic               kabul0,
    output logic               kabul1,
    output logic               fsm_reset,
    output logic               fsm_giris,
    input  logic               fsm_cikis,
    output logic [UZUNLUK-1:0] sonuc,
    output logic               sonuc_gecerli,
    output logic               sonuc_kimlik,
    output logic               mesgul
);

    localparam int unsigned   SW      = $clog2(UZUNLUK);
    localparam logic [SW-1:0] SON_BIT = SW'(UZUNLUK - 1);
    localparam logic [SW-1:0] BIR     = SW'(1);

    typedef enum logic [2:0] {
        StBosta,
        StTemizle,
        StKaydir,
        StOrnek,
        StTamam
    } durum_e;

    durum_e             durum_q, durum_d;
    logic [SW-1:0]      sayac_q;
    logic [UZUNLUK-1:0] kelime_q;
    logic [UZUNLUK-2:0] topla_q;
    logic [UZUNLUK-1:0] sonuc_q;
    logic               kimlik_q;
    logic               son_q;
    logic               sonuc_kimlik_q;
    logic               secim;
    logic               temizle;

    // Contention goes to the requester not served last; otherwise the only requester wins.
    always_comb begin
        if (istek0 && istek1) begin
            secim = ~son_q;
        end else begin
            secim = ~istek0;
        end
    end

    always_ff @(posedge saat or negedge reset) begin
        if (!reset) begin
            durum_q <= StBosta;
        end else begin
            durum_q <= durum_d;
        end
    end

    always_comb begin
        durum_d       = durum_q;
        kabul0        = 1'b0;
        kabul1        = 1'b0;
        temizle       = 1'b0;
        fsm_giris     = 1'b0;
        sonuc_gecerli = 1'b0;
        unique case (durum_q)
            StBosta: begin
                if (istek0 || istek1) begin
                    durum_d = StTemizle;
                end
            end
            StTemizle: begin
                durum_d = StKaydir;
                kabul0  = ~kimlik_q;
                kabul1  = kimlik_q;
                temizle = 1'b1;
            end
            StKaydir: begin
                fsm_giris = kelime_q[sayac_q];
                if (sayac_q == SON_BIT) begin
                    durum_d = StOrnek;
                end
            end
            StOrnek: begin
                durum_d = StTamam;
            end
            StTamam: begin
                durum_d       = StBosta;
                sonuc_gecerli = 1'b1;
            end
            default: begin
                durum_d = StBosta;
            end
        endcase
    end

    // The external FSM is held in reset along with this block.
    assign fsm_reset    = ~reset | temizle;
    assign mesgul       = (durum_q != StBosta);
    assign sonuc        = sonuc_q;
    assign sonuc_kimlik = sonuc_kimlik_q;

    always_ff @(posedge saat or negedge reset) begin
        if (!reset) begin
            sayac_q        <= '0;
            kelime_q       <= '0;
            topla_q        <= '0;
            sonuc_q        <= '0;
            kimlik_q       <= 1'b0;
            son_q          <= 1'b1;
            sonuc_kimlik_q <= 1'b0;
        end else begin
            case (durum_q)
                StBosta: begin
                    if (istek0 || istek1) begin
                        kelime_q <= secim ? veri1 : veri0;
                        kimlik_q <= secim;
                        son_q    <= secim;
                    end
                end
                StTemizle: begin
                    sayac_q <= '0;
                end
                StKaydir: begin
                    // fsm_cikis now shows the state after bit sayac_q-1 was consumed.
                    if (sayac_q != '0) begin
                        topla_q[sayac_q - BIR] <= fsm_cikis;
                    end
                    sayac_q <= sayac_q + BIR;
                end
                StOrnek: begin
                    // Last bit is taken straight into the result so it is visible in TAMAM.
                    sonuc_q        <= {fsm_cikis, topla_q};
                    sonuc_kimlik_q <= kimlik_q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_durum_zamanlayici.sv
// Bench for durum_zamanlayici with a behavioural model of the external serial detector.
module tb_durum_zamanlayici;

    localparam int N = 8;

    logic         saat = 1'b0;
    logic         reset = 1'b0;
    logic         istek0 = 1'b0;
    logic         istek1 = 1'b0;
    logic [N-1:0] veri0 = '0;
    logic [N-1:0] veri1 = '0;
    logic         kabul0, kabul1, fsm_reset, fsm_giris, fsm_cikis;
    logic [N-1:0] sonuc;
    logic         sonuc_gecerli, sonuc_kimlik, mesgul;

    durum_zamanlayici #(.UZUNLUK(N)) dut (
        .saat          (saat),
        .reset         (reset),
        .istek0        (istek0),
        .istek1        (istek1),
        .veri0         (veri0),
        .veri1         (veri1),
        .kabul0        (kabul0),
        .kabul1        (kabul1),
        .fsm_reset     (fsm_reset),
        .fsm_giris     (fsm_giris),
        .fsm_cikis     (fsm_cikis),
        .sonuc         (sonuc),
        .sonuc_gecerli (sonuc_gecerli),
        .sonuc_kimlik  (sonuc_kimlik),
        .mesgul        (mesgul)
    );

    always #5 saat = ~saat;

    int cevrim = 0;
    always @(posedge saat) cevrim <= cevrim + 1;

    // External detector: output 1 right after a 1; after a zero run it is 1 when the run
    // length is 2 mod 3 (a 1 was seen) or 0 mod 3 (no 1 seen since reset).
    logic       det_basla, det_bir, det_son;
    logic [1:0] det_z;
    always @(posedge saat) begin
        if (fsm_reset) begin
            det_basla <= 1'b0;
            det_bir   <= 1'b0;
            det_son   <= 1'b0;
            det_z     <= 2'd0;
        end else begin
            det_basla <= 1'b1;
            if (fsm_giris) begin
                det_bir <= 1'b1;
                det_son <= 1'b1;
                det_z   <= 2'd0;
            end else begin
                det_son <= 1'b0;
                det_z   <= (det_z == 2'd2) ? 2'd0 : det_z + 2'd1;
            end
        end
    end
    assign fsm_cikis = det_basla & (det_son | (det_bir ? (det_z == 2'd2) : (det_z == 2'd0)));

    int kontrol_sayisi = 0;
    int hata_sayisi = 0;

    task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] bek);
        kontrol_sayisi++;
        if (gercek !== bek) begin
            hata_sayisi++;
            $display("FAIL %s: got=%0h expected=%0h", ad, gercek, bek);
        end
    endtask

    // Result bit j is the detector output after consuming word bits 0..j.
    function automatic logic [N-1:0] beklenen_sonuc(input logic [N-1:0] w);
        logic [N-1:0] r;
        int son_bir;
        r = '0;
        for (int j = 0; j < N; j++) begin
            son_bir = -1;
            for (int i = 0; i <= j; i++) if (w[i]) son_bir = i;
            if (son_bir == j)     r[j] = 1'b1;
            else if (son_bir < 0) r[j] = ((j + 1) % 3 == 0);
            else                  r[j] = ((j - son_bir) % 3 == 2);
        end
        return r;
    endfunction

    // Waits for a grant, then follows the job to its result and checks it.
    task automatic job_izle(input int kim, input logic [N-1:0] kelime, input logic [N-1:0] bek,
                            input bit degistir, input string ad);
        bit           bulundu;
        int           lat;
        logic [N-1:0] giris_izi;
        bulundu   = 1'b0;
        giris_izi = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge saat);
            if (kabul0 || kabul1) begin
                bulundu = 1'b1;
                break;
            end
        end
        if (!bulundu) begin
            kontrol({ad, "_kabul_zaman_asimi"}, 32'd0, 32'd1);
            return;
        end
        kontrol({ad, "_kabul"}, 32'({kabul1, kabul0}), (kim == 0) ? 32'd1 : 32'd2);
        kontrol({ad, "_fsm_reset_temizle"}, 32'(fsm_reset), 32'd1);
        kontrol({ad, "_mesgul"}, 32'(mesgul), 32'd1);
        if (kim == 0) begin
            istek0 = 1'b0;
            if (degistir) veri0 = ~veri0;
        end else begin
            istek1 = 1'b0;
            if (degistir) veri1 = ~veri1;
        end
        bulundu = 1'b0;
        lat     = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge saat);
            if (i <= N) giris_izi[i-1] = fsm_giris;
            if (sonuc_gecerli) begin
                lat     = i;
                bulundu = 1'b1;
                break;
            end
        end
        kontrol({ad, "_gecikme"}, 32'(lat), 32'(N + 2));
        kontrol({ad, "_seri_giris"}, 32'(giris_izi), 32'(kelime));
        kontrol({ad, "_sonuc"}, 32'(sonuc), 32'(bek));
        kontrol({ad, "_kimlik"}, 32'(sonuc_kimlik), 32'(kim));
        if (bulundu) begin
            @(negedge saat);
            kontrol({ad, "_gecerli_tek"}, 32'(sonuc_gecerli), 32'd0);
            kontrol({ad, "_sonuc_tutma"}, 32'(sonuc), 32'(bek));
            kontrol({ad, "_bosta"}, 32'(mesgul), 32'd0);
        end
    endtask

    typedef struct {
        int           kim;
        logic [N-1:0] veri;
        logic [N-1:0] sonuc;
        bit           degistir;
    } vektor_t;

    vektor_t tablo[5];
    int      kim_l[$];
    int      zaman_l[$];
    int      son_kim;
    bit      bekl0, bekl1, gordu;
    int      kim;
    logic [N-1:0] kelime;

    initial begin
        tablo[0] = '{kim: 0, veri: 8'hFF, sonuc: 8'hFF, degistir: 1'b0};
        tablo[1] = '{kim: 1, veri: 8'h00, sonuc: 8'h24, degistir: 1'b0};
        tablo[2] = '{kim: 0, veri: 8'h02, sonuc: 8'h4A, degistir: 1'b0};
        tablo[3] = '{kim: 0, veri: 8'h01, sonuc: 8'h25, degistir: 1'b1};
        tablo[4] = '{kim: 1, veri: 8'h80, sonuc: 8'hA4, degistir: 1'b1};

        // Reset state
        repeat (2) @(negedge saat);
        kontrol("reset_kabul", 32'({kabul1, kabul0}), 32'd0);
        kontrol("reset_fsm_reset", 32'(fsm_reset), 32'd1);
        kontrol("reset_fsm_giris", 32'(fsm_giris), 32'd0);
        kontrol("reset_sonuc", 32'(sonuc), 32'd0);
        kontrol("reset_gecerli", 32'(sonuc_gecerli), 32'd0);
        kontrol("reset_kimlik", 32'(sonuc_kimlik), 32'd0);
        kontrol("reset_mesgul", 32'(mesgul), 32'd0);
        reset = 1'b1;
        @(negedge saat);
        kontrol("bosta_fsm_reset", 32'(fsm_reset), 32'd0);

        // Abort mid-shift, then the still-held request is granted again
        istek0 = 1'b1;
        veri0  = 8'hFF;
        gordu  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge saat);
            if (kabul0) begin
                gordu = 1'b1;
                break;
            end
        end
        kontrol("iptal_kabul", 32'(gordu), 32'd1);
        repeat (3) @(negedge saat);
        kontrol("iptal_once_mesgul", 32'(mesgul), 32'd1);
        #2 reset = 1'b0;
        #1;
        kontrol("iptal_mesgul", 32'(mesgul), 32'd0);
        kontrol("iptal_fsm_reset", 32'(fsm_reset), 32'd1);
        kontrol("iptal_fsm_giris", 32'(fsm_giris), 32'd0);
        kontrol("iptal_sonuc", 32'(sonuc), 32'd0);
        gordu = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge saat);
            if (sonuc_gecerli) gordu = 1'b1;
        end
        kontrol("iptal_gecerli_yok", 32'(gordu), 32'd0);
        reset = 1'b1;
        job_izle(0, 8'hFF, 8'hFF, 1'b0, "iptal_sonrasi");

        // Directed vectors
        foreach (tablo[k]) begin
            if (tablo[k].kim == 0) begin
                istek0 = 1'b1;
                veri0  = tablo[k].veri;
            end else begin
                istek1 = 1'b1;
                veri1  = tablo[k].veri;
            end
            job_izle(tablo[k].kim, tablo[k].veri, tablo[k].sonuc, tablo[k].degistir, "tablo");
        end

        // Both requests held from reset
        reset  = 1'b0;
        istek0 = 1'b1;
        istek1 = 1'b1;
        veri0  = 8'h5A;
        veri1  = 8'h3C;
        repeat (2) @(negedge saat);
        reset = 1'b1;
        for (int i = 0; i < 60 && kim_l.size() < 3; i++) begin
            @(negedge saat);
            kontrol("hakem_ikisi_birden", 32'(kabul0 & kabul1), 32'd0);
            if (kabul0) begin
                kim_l.push_back(0);
                zaman_l.push_back(cevrim);
            end else if (kabul1) begin
                kim_l.push_back(1);
                zaman_l.push_back(cevrim);
            end
        end
        istek0 = 1'b0;
        istek1 = 1'b0;
        kontrol("hakem_sayi", 32'(kim_l.size()), 32'd3);
        if (kim_l.size() == 3) begin
            kontrol("hakem_sira0", 32'(kim_l[0]), 32'd0);
            kontrol("hakem_sira1", 32'(kim_l[1]), 32'd1);
            kontrol("hakem_sira2", 32'(kim_l[2]), 32'd0);
            kontrol("hakem_aralik1", 32'(zaman_l[1] - zaman_l[0]), 32'(N + 4));
            kontrol("hakem_aralik2", 32'(zaman_l[2] - zaman_l[1]), 32'(N + 4));
        end
        gordu = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge saat);
            if (!mesgul) begin
                gordu = 1'b1;
                break;
            end
        end
        kontrol("hakem_bitis", 32'(gordu), 32'd1);
        kontrol("hakem_son_sonuc", 32'(sonuc), 32'(beklenen_sonuc(8'h5A)));
        kontrol("hakem_son_kimlik", 32'(sonuc_kimlik), 32'd0);

        // Randomized traffic against the reference model
        son_kim = 0;
        bekl0   = 1'b0;
        bekl1   = 1'b0;
        for (int it = 0; it < 40; it++) begin
            if (!bekl0 && $urandom_range(1, 0) == 1) begin
                bekl0  = 1'b1;
                veri0  = N'($urandom);
                istek0 = 1'b1;
            end
            if (!bekl1 && $urandom_range(1, 0) == 1) begin
                bekl1  = 1'b1;
                veri1  = N'($urandom);
                istek1 = 1'b1;
            end
            if (!bekl0 && !bekl1) begin
                bekl0  = 1'b1;
                veri0  = N'($urandom);
                istek0 = 1'b1;
            end
            kim    = (bekl0 && bekl1) ? 1 - son_kim : (bekl0 ? 0 : 1);
            kelime = (kim == 1) ? veri1 : veri0;
            job_izle(kim, kelime, beklenen_sonuc(kelime), $urandom_range(1, 0) == 1, "rastgele");
            if (kim == 0) bekl0 = 1'b0;
            else          bekl1 = 1'b0;
            son_kim = kim;
        end
        istek0 = 1'b0;
        istek1 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", kontrol_sayisi, hata_sayisi);
        $finish;
    end

endmodule

// File: doc/durum_zamanlayici.md
DURUM_ZAMANLAYICI -- requirements
Module: durum_zamanlayici

Interface
REQ-001 Parameter: UZUNLUK, default 8, word length in bits processed per job; legal range 2..16.
REQ-002 saat  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; low forces the reset state immediately, independent of saat.
REQ-004 istek0, istek1  input  1 each  job request from requester 0 / 1; held high until the matching kabul pulse.
REQ-005 veri0, veri1  input  UZUNLUK each  input word of requester 0 / 1; valid while its istek is high.
REQ-006 kabul0, kabul1  output  1 each  one-cycle grant pulse to requester 0 / 1.
REQ-007 fsm_reset  output  1  active-high synchronous reset to the shared serial detector FSM.
REQ-008 fsm_giris  output  1  serial bit driven into the FSM input.
REQ-009 fsm_cikis  input  1  Moore output of the FSM, reflecting its registered state.
REQ-010 sonuc  output  UZUNLUK  collected FSM output bits of the last completed job.
REQ-011 sonuc_gecerli  output  1  one-cycle pulse when sonuc is updated.
REQ-012 sonuc_kimlik  output  1  requester index owning the current sonuc.
REQ-013 mesgul  output  1  high whenever the controller is not in BOSTA.

Function
REQ-014 States: BOSTA, TEMIZLE, KAYDIR, ORNEK, TAMAM; all outputs derived from registered state/datapath.
REQ-015 BOSTA: if any istek high at the edge, go TEMIZLE, latch the granted requester's word and index; else stay.
REQ-016 Arbitration: single request wins; both high -> requester not served last wins; after reset, requester 0 wins first.
REQ-017 kabulX is high exactly during the TEMIZLE cycle of requester X's job; never both high.
REQ-018 TEMIZLE: fsm_reset=1, fsm_giris=0, for exactly one cycle; then KAYDIR with bit counter=0.
REQ-019 KAYDIR: UZUNLUK cycles; fsm_giris = latched word[counter], LSB first; counter increments each cycle.
REQ-020 Sampling: in KAYDIR cycle with counter k>=1, capture fsm_cikis into result bit k-1; in ORNEK, capture into bit UZUNLUK-1.
REQ-021 ORNEK: one cycle, fsm_giris=0; then TAMAM.
REQ-022 TAMAM: one cycle; sonuc takes collected bits, sonuc_kimlik the job index, sonuc_gecerli=1; then BOSTA.
REQ-023 Latency: kabul in cycle t -> sonuc_gecerli in cycle t+UZUNLUK+2; sonuc visible from that cycle.
REQ-024 sonuc and sonuc_kimlik hold their value until the next TAMAM.
REQ-025 istek is ignored outside BOSTA; minimum spacing between successive kabul pulses is UZUNLUK+4 cycles.
REQ-026 Word is latched at grant; veri changes after kabul do not affect the running job.
REQ-027 fsm_reset = 1 while reset is low or in TEMIZLE; 0 otherwise.

Reset
REQ-028 reset low: state BOSTA, counter 0, kabul0/1=0, fsm_giris=0, sonuc=0, sonuc_gecerli=0, sonuc_kimlik=0, mesgul=0, last-served=1.
REQ-029 reset low mid-job aborts the job with no sonuc_gecerli; after release, a held istek is granted from BOSTA normally.

Verification
REQ-030 istek0=1, veri0=8'hFF -> kabul0 cycle t, sonuc_gecerli at t+10, sonuc=8'hFF, sonuc_kimlik=0.
REQ-031 istek1=1, veri1=8'h00 -> kabul1, sonuc=8'h24, sonuc_kimlik=1, 10 cycles after kabul1.
REQ-032 istek0=1, veri0=8'h02 -> sonuc=8'h4A.
REQ-033 istek0 and istek1 both held high from reset -> order kabul0, kabul1, kabul0; grants UZUNLUK+4=12 cycles apart.
REQ-034 reset pulled low during KAYDIR -> immediately mesgul=0, fsm_reset=1, no sonuc_gecerli; sonuc keeps reset value 0.
REQ-035 veri0 changed in cycle after kabul0 -> sonuc matches word sampled at grant.
